// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//   Instruction-fetch front end. Owns the fetch PC, issues requests to a
//   synchronous icache with one cycle of read latency, and buffers the
//   returned words together with their PCs in a DEPTH-entry FIFO. Decode can
//   drain the FIFO while the icache is stalled. A redirect from execute
//   flushes the FIFO, drops any stale in-flight response and restarts fetch.
//
//   Parameters
//     DEPTH        FIFO entries (power of 2, >= 2)
//     RESET_PC     first fetch address after reset
//
//   Ports
//     clk          rising-edge clock
//     reset        synchronous, active-high
//     icache_addr  fetch address, word aligned
//     icache_re    request issued this cycle
//     icache_dout  read data for the request accepted in the previous
//                  unstalled cycle
//     stall        memory stall: no request accepted, dout not valid
//     redirect     flush and restart fetch at redirect_pc
//     redirect_pc  new fetch PC (bits [1:0] ignored)
//     deq_valid    head entry valid
//     deq_ready    decode consumes the head when deq_valid is set
//     deq_instr    head instruction
//     deq_pc       head PC
//     count        valid entries held in the FIFO (excludes in-flight)
// -----------------------------------------------------------------------------
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_2000
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic [31:0]              icache_addr,
    output logic                     icache_re,
    input  logic [31:0]              icache_dout,
    input  logic                     stall,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    output logic                     deq_valid,
    input  logic                     deq_ready,
    output logic [31:0]              deq_instr,
    output logic [31:0]              deq_pc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0]   DEPTH_OCC = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    logic [31:0]   fpc_p0;
    logic          vld_p0;
    logic          kill_p0;
    logic [31:0]   req_pc_p0;

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_nxt;

    logic [31:0]   instr_mem [DEPTH];
    logic [31:0]   pc_mem    [DEPTH];

    logic [31:0]   redirect_addr;
    logic [CW:0]   occ;
    logic          deq_fire;
    logic          enq;
    logic          issue;

    // ---- stage p0: request issue ---------------------------------------------
    // Credits count the in-flight word unless it is already marked for
    // discard, so an issue is never made without a FIFO slot to receive it.
    assign redirect_addr = {redirect_pc[31:2], 2'b00};
    assign deq_valid     = ~reset & (count_q != '0);
    assign deq_fire      = deq_valid & deq_ready & ~redirect;
    assign occ           = {1'b0, count_q} + {{CW{1'b0}}, vld_p0 & ~kill_p0};
    assign issue         = ~reset & ~stall & (redirect | (occ < DEPTH_OCC) | deq_fire);
    assign icache_addr   = redirect ? redirect_addr : fpc_p0;
    assign icache_re     = issue;

    // ---- stage p1: response capture into the FIFO ---------------------------
    assign enq = ~reset & ~stall & vld_p0 & ~kill_p0 & ~redirect;

    always_comb begin
        count_nxt = count_q;
        case ({enq, deq_fire})
            2'b10:   count_nxt = count_q + CW'(1);
            2'b01:   count_nxt = count_q - CW'(1);
            default: count_nxt = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fpc_p0  <= RESET_PC;
            vld_p0  <= 1'b0;
            kill_p0 <= 1'b0;
            count_q <= '0;
            head    <= '0;
            tail    <= '0;
        end else begin
            if (issue) begin
                fpc_p0  <= icache_addr + 32'd4;
                vld_p0  <= 1'b1;
                kill_p0 <= 1'b0;
            end else begin
                // A stalled redirect parks the new PC and poisons the
                // outstanding response; the next issue clears the poison.
                if (redirect) begin
                    fpc_p0  <= redirect_addr;
                    kill_p0 <= 1'b1;
                end
                if (!stall) begin
                    vld_p0 <= 1'b0;
                end
            end

            if (redirect) begin
                count_q <= '0;
                head    <= tail;
            end else begin
                count_q <= count_nxt;
                if (deq_fire) begin
                    head <= head + PW'(1);
                end
                if (enq) begin
                    tail <= tail + PW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (issue) begin
            req_pc_p0 <= icache_addr;
        end
        if (enq) begin
            instr_mem[tail] <= icache_dout;
            pc_mem[tail]    <= req_pc_p0;
        end
    end

    // ---- stage p2: FIFO head to decode --------------------------------------
    assign deq_instr = instr_mem[head];
    assign deq_pc    = pc_mem[head];
    assign count     = count_q;

    a_no_overflow : assert property (@(posedge clk) disable iff (reset)
        !(enq && !deq_fire && (count_q == DEPTH_CNT)));

endmodule
